// File: rtl/exu_mul_pkg.sv
// Shared types and constants for the pipelined multiply controller.
// The struct widths follow the default register/commit widths.
package exu_mul_pkg;

  localparam int unsigned REG_DATA_WIDTH  = 32;
  localparam int unsigned REG_ADDR_WIDTH  = 5;
  localparam int unsigned COMMIT_ID_WIDTH = 3;

  // Bit positions inside the one-hot mul_op vector
  localparam int unsigned MUL_OP_MUL    = 0;
  localparam int unsigned MUL_OP_MULH   = 1;
  localparam int unsigned MUL_OP_MULHSU = 2;
  localparam int unsigned MUL_OP_MULHU  = 3;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0]  waddr;
    logic                       we;
    logic [COMMIT_ID_WIDTH-1:0] cid;
  } mul_tag_t;

  typedef struct packed {
    mul_tag_t                  tag;
    logic [REG_DATA_WIDTH-1:0] data;
  } mul_res_t;

endpackage

// File: rtl/exu_mul_ctrl_pipe_if.sv
// Start/return channel between the multiply controller and the pipelined multiplier.
interface exu_mul_ctrl_pipe_if #(
  parameter int unsigned XLEN = 32
);

  logic            mul_start_o;
  logic [XLEN-1:0] mul_multiplicand_o;
  logic [XLEN-1:0] mul_multiplier_o;
  logic [3:0]      mul_op_o;
  logic            mul_ready_i;
  logic            mul_valid_i;
  logic [XLEN-1:0] mul_result_i;

  modport master (
    output mul_start_o, mul_multiplicand_o, mul_multiplier_o, mul_op_o,
    input  mul_ready_i, mul_valid_i, mul_result_i
  );

  modport slave (
    input  mul_start_o, mul_multiplicand_o, mul_multiplier_o, mul_op_o,
    output mul_ready_i, mul_valid_i, mul_result_i
  );

endinterface

// File: rtl/exu_mul_fifo.sv
// Synchronous FIFO with clear; head holds the last shown entry while empty.
module exu_mul_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DW-1:0]            head
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic [DW-1:0] last_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last_q <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last_q <= head;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/exu_mul_ctrl_pipe.sv
// Multiply control unit: issues up to DEPTH multiplies, tracks their writeback
// tags in order, buffers results for the WBU and drops results killed by flush.
module exu_mul_ctrl_pipe
  import exu_mul_pkg::*;
#(
  parameter int unsigned XLEN  = REG_DATA_WIDTH,
  parameter int unsigned AW    = REG_ADDR_WIDTH,
  parameter int unsigned CW    = COMMIT_ID_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_mul_i,
  input  logic [3:0]          mul_op_i,
  input  logic [XLEN-1:0]     reg1_rdata_i,
  input  logic [XLEN-1:0]     reg2_rdata_i,
  input  logic [AW-1:0]       reg_waddr_i,
  input  logic                reg_we_i,
  input  logic [CW-1:0]       commit_id_i,
  input  logic                int_assert_i,
  input  logic                flush_i,
  exu_mul_ctrl_pipe_if.master mul_if,
  output logic                mul_stall_o,
  input  logic                wb_ready_i,
  output logic                reg_we_o,
  output logic [AW-1:0]       reg_waddr_o,
  output logic [XLEN-1:0]     reg_wdata_o,
  output logic [CW-1:0]       commit_id_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] waddr;
    logic          we;
    logic [CW-1:0] cid;
  } tag_t;

  typedef struct packed {
    tag_t            tag;
    logic [XLEN-1:0] data;
  } res_t;

  logic [CNT_W-1:0] tag_cnt;
  logic [CNT_W-1:0] res_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] drop_nxt;
  logic [CNT_W-1:0] drop_sum;
  logic [CNT_W:0]   occ;
  logic             tag_full, tag_empty;
  logic             res_full, res_empty;
  logic             issue;
  logic             ret_ok;
  logic             res_pop;
  tag_t             tag_in;
  tag_t             tag_head;
  res_t             res_in;
  res_t             res_head;

  assign occ   = {1'b0, tag_cnt} + {1'b0, res_cnt};
  assign issue = req_mul_i & ~int_assert_i & ~flush_i & mul_if.mul_ready_i
               & (occ < (CNT_W+1)'(DEPTH)) & (drop_cnt == '0);

  assign mul_if.mul_start_o        = issue;
  assign mul_if.mul_multiplicand_o = reg1_rdata_i;
  assign mul_if.mul_multiplier_o   = reg2_rdata_i;
  assign mul_if.mul_op_o           = mul_op_i;
  assign mul_stall_o               = req_mul_i & ~int_assert_i & ~issue;

  // A return is kept only when no flushed results are still owed
  assign ret_ok = mul_if.mul_valid_i & ~flush_i & (drop_cnt == '0) & ~tag_empty;

  assign tag_in = '{waddr: reg_waddr_i, we: reg_we_i, cid: commit_id_i};
  assign res_in = '{tag: tag_head, data: mul_if.mul_result_i};

  // Non-writing entries retire on their own; flush beats a pending writeback
  assign res_pop = ~res_empty & (~res_head.tag.we | wb_ready_i) & ~flush_i;

  exu_mul_fifo #(
    .DW    ($bits(tag_t)),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue),
    .push_data (tag_in),
    .pop       (ret_ok),
    .clear     (flush_i),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_cnt),
    .head      (tag_head)
  );

  exu_mul_fifo #(
    .DW    ($bits(res_t)),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ret_ok),
    .push_data (res_in),
    .pop       (res_pop),
    .clear     (flush_i),
    .full      (res_full),
    .empty     (res_empty),
    .count     (res_cnt),
    .head      (res_head)
  );

  assign reg_we_o    = ~res_empty & res_head.tag.we;
  assign reg_waddr_o = res_head.tag.waddr;
  assign reg_wdata_o = res_head.data;
  assign commit_id_o = res_head.tag.cid;

  // Issue is blocked while drop_cnt > 0, so drop_cnt + tag_cnt never exceeds DEPTH
  always_comb begin
    drop_sum = drop_cnt + tag_cnt;
    drop_nxt = drop_cnt;
    if (flush_i) begin
      if (mul_if.mul_valid_i && drop_sum != '0) drop_nxt = drop_sum - 1'b1;
      else                                      drop_nxt = drop_sum;
    end else if (mul_if.mul_valid_i && drop_cnt != '0) begin
      drop_nxt = drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else        drop_cnt <= drop_nxt;
  end

  a_no_orphan_return: assert property (@(posedge clk) disable iff (!rst_n)
    !(mul_if.mul_valid_i && tag_empty && drop_cnt == '0));

  a_no_tag_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(issue && tag_full && !ret_ok));

  a_no_res_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(ret_ok && res_full && !res_pop));

endmodule

// File: tb/tb_exu_mul_ctrl_pipe.sv
// Directed bench for exu_mul_ctrl_pipe with a 3-cycle pipelined multiplier model.
module tb_exu_mul_ctrl_pipe;
  import exu_mul_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned CW    = 3;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_mul_i;
  logic [3:0]      mul_op_i;
  logic [XLEN-1:0] reg1_rdata_i;
  logic [XLEN-1:0] reg2_rdata_i;
  logic [AW-1:0]   reg_waddr_i;
  logic            reg_we_i;
  logic [CW-1:0]   commit_id_i;
  logic            int_assert_i;
  logic            flush_i;
  logic            mul_stall_o;
  logic            wb_ready_i;
  logic            reg_we_o;
  logic [AW-1:0]   reg_waddr_o;
  logic [XLEN-1:0] reg_wdata_o;
  logic [CW-1:0]   commit_id_o;

  exu_mul_ctrl_pipe_if #(.XLEN(XLEN)) mif ();

  exu_mul_ctrl_pipe #(
    .XLEN  (XLEN),
    .AW    (AW),
    .CW    (CW),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_mul_i    (req_mul_i),
    .mul_op_i     (mul_op_i),
    .reg1_rdata_i (reg1_rdata_i),
    .reg2_rdata_i (reg2_rdata_i),
    .reg_waddr_i  (reg_waddr_i),
    .reg_we_i     (reg_we_i),
    .commit_id_i  (commit_id_i),
    .int_assert_i (int_assert_i),
    .flush_i      (flush_i),
    .mul_if       (mif),
    .mul_stall_o  (mul_stall_o),
    .wb_ready_i   (wb_ready_i),
    .reg_we_o     (reg_we_o),
    .reg_waddr_o  (reg_waddr_o),
    .reg_wdata_o  (reg_wdata_o),
    .commit_id_o  (commit_id_o)
  );

  always #5 clk = ~clk;

  // Multiplier model: fixed 3-cycle latency, low product
  logic [2:0]      pv;
  logic [XLEN-1:0] pd [3];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
    end else begin
      pv    <= {pv[1:0], mif.mul_start_o};
      pd[0] <= mif.mul_multiplicand_o * mif.mul_multiplier_o;
      pd[1] <= pd[0];
      pd[2] <= pd[1];
    end
  end
  assign mif.mul_valid_i  = pv[2];
  assign mif.mul_result_i = pd[2];

  // WBU-side log of accepted writebacks
  logic [CW-1:0]   log_cid  [$];
  logic [AW-1:0]   log_addr [$];
  logic [XLEN-1:0] log_data [$];
  logic            bad_we;
  always @(posedge clk) begin
    if (rst_n && reg_we_o && wb_ready_i && !flush_i) begin
      log_cid.push_back(commit_id_o);
      log_addr.push_back(reg_waddr_o);
      log_data.push_back(reg_wdata_o);
    end
    if (rst_n && reg_we_o && reg_waddr_o == 5'd3) bad_we = 1'b1;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_mul_i    = 1'b0;
    mul_op_i     = '0;
    reg1_rdata_i = '0;
    reg2_rdata_i = '0;
    reg_waddr_i  = '0;
    reg_we_i     = 1'b0;
    commit_id_i  = '0;
  endtask

  task automatic set_req(input logic [AW-1:0] wa, input logic we, input logic [CW-1:0] cid,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req_mul_i    = 1'b1;
    mul_op_i     = 4'b0001 << MUL_OP_MUL;
    reg1_rdata_i = a;
    reg2_rdata_i = b;
    reg_waddr_i  = wa;
    reg_we_i     = we;
    commit_id_i  = cid;
  endtask

  task automatic clear_log();
    log_cid.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic check_log(input string tag, input int idx, input logic [CW-1:0] cid,
                           input logic [XLEN-1:0] data);
    if (idx < log_cid.size()) begin
      chk({tag, "_cid"}, 64'(log_cid[idx]), 64'(cid));
      chk({tag, "_data"}, 64'(log_data[idx]), 64'(data));
    end else begin
      chk({tag, "_missing"}, 64'(log_cid.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [XLEN-1:0] t1_exp [4];
    bit seen;
    t1_exp = '{32'd11, 32'd24, 32'd39, 32'd56};

    rst_n            = 1'b0;
    idle();
    mif.mul_ready_i  = 1'b1;
    wb_ready_i       = 1'b1;
    flush_i          = 1'b0;
    int_assert_i     = 1'b0;
    bad_we           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 64'(reg_we_o), 64'd0);
    chk("rst_stall", 64'(mul_stall_o), 64'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back issue, in-order retirement
    clear_log();
    for (int i = 1; i <= 4; i++) begin
      set_req(AW'(i), 1'b1, CW'(i), XLEN'(i), XLEN'(i + 10));
      #1;
      chk("t1_start", 64'(mif.mul_start_o), 64'd1);
      chk("t1_stall", 64'(mul_stall_o), 64'd0);
      step();
    end
    idle();
    repeat (12) step();
    chk("t1_count", 64'(log_cid.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_log("t1", i, CW'(i + 1), t1_exp[i]);

    // Backpressure: occupancy limit then release
    clear_log();
    wb_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_req(AW'(i), 1'b1, CW'(i), XLEN'(i), 32'd2);
      #1;
      chk("t2_start", 64'(mif.mul_start_o), 64'd1);
      step();
    end
    set_req(5'd5, 1'b1, 3'd5, 32'd5, 32'd2);
    #1;
    chk("t2_stall5", 64'(mul_stall_o), 64'd1);
    chk("t2_nostart5", 64'(mif.mul_start_o), 64'd0);
    repeat (6) step();
    chk("t2_still_stall", 64'(mul_stall_o), 64'd1);
    chk("t2_head_we", 64'(reg_we_o), 64'd1);
    wb_ready_i = 1'b1;
    #1;
    chk("t2_no_bypass", 64'(mif.mul_start_o), 64'd0);
    step();
    chk("t2_start5", 64'(mif.mul_start_o), 64'd1);
    step();
    set_req(5'd6, 1'b1, 3'd6, 32'd6, 32'd2);
    #1;
    chk("t2_start6", 64'(mif.mul_start_o), 64'd1);
    step();
    idle();
    repeat (12) step();
    chk("t2_count", 64'(log_cid.size()), 64'd6);
    for (int i = 0; i < 6; i++) check_log("t2", i, CW'(i + 1), XLEN'((i + 1) * 2));

    // Zero-write entry retires silently
    clear_log();
    bad_we = 1'b0;
    set_req(5'd3, 1'b0, 3'd1, 32'd5, 32'd6);
    #1;
    chk("t3_start0", 64'(mif.mul_start_o), 64'd1);
    step();
    set_req(5'd7, 1'b1, 3'd2, 32'h1234_5678, 32'd1);
    #1;
    chk("t3_start1", 64'(mif.mul_start_o), 64'd1);
    step();
    idle();
    repeat (10) step();
    chk("t3_count", 64'(log_cid.size()), 64'd1);
    chk("t3_silent", 64'(bad_we), 64'd0);
    if (log_addr.size() > 0) chk("t3_waddr", 64'(log_addr[0]), 64'd7);
    check_log("t3", 0, 3'd2, 32'h1234_5678);

    // Flush with three in flight as the first result returns
    clear_log();
    for (int i = 1; i <= 3; i++) begin
      set_req(AW'(i), 1'b1, CW'(i), XLEN'(i), 32'd3);
      step();
    end
    idle();
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (pv[2]) seen = 1'b1;
      else       step();
    end
    chk("t4_valid_seen", 64'(seen), 64'd1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    set_req(5'd4, 1'b1, 3'd5, 32'd7, 32'd7);
    #1;
    chk("t4_block_a", 64'(mif.mul_start_o), 64'd0);
    chk("t4_stall_a", 64'(mul_stall_o), 64'd1);
    step();
    chk("t4_block_b", 64'(mif.mul_start_o), 64'd0);
    step();
    chk("t4_resume", 64'(mif.mul_start_o), 64'd1);
    step();
    idle();
    repeat (10) step();
    chk("t4_count", 64'(log_cid.size()), 64'd1);
    check_log("t4", 0, 3'd5, 32'd49);

    // Interrupt blocks issue only
    clear_log();
    wb_ready_i = 1'b0;
    set_req(5'd1, 1'b1, 3'd1, 32'd3, 32'd4);
    step();
    set_req(5'd2, 1'b1, 3'd2, 32'd5, 32'd6);
    step();
    idle();
    repeat (6) step();
    chk("t5_buffered", 64'(reg_we_o), 64'd1);
    int_assert_i = 1'b1;
    wb_ready_i   = 1'b1;
    set_req(5'd3, 1'b1, 3'd3, 32'd9, 32'd9);
    #1;
    chk("t5_nostart", 64'(mif.mul_start_o), 64'd0);
    chk("t5_nostall", 64'(mul_stall_o), 64'd0);
    step();
    chk("t5_nostart2", 64'(mif.mul_start_o), 64'd0);
    repeat (3) step();
    idle();
    int_assert_i = 1'b0;
    repeat (4) step();
    chk("t5_count", 64'(log_cid.size()), 64'd2);
    check_log("t5a", 0, 3'd1, 32'd12);
    check_log("t5b", 1, 3'd2, 32'd30);

    // Flush while a result is on the writeback bus
    clear_log();
    wb_ready_i = 1'b0;
    set_req(5'd1, 1'b1, 3'd1, 32'd9, 32'd9);
    step();
    idle();
    repeat (5) step();
    chk("t6_on_bus", 64'(reg_we_o), 64'd1);
    flush_i    = 1'b1;
    wb_ready_i = 1'b1;
    step();
    flush_i = 1'b0;
    #1;
    chk("t6_cleared", 64'(reg_we_o), 64'd0);
    set_req(5'd2, 1'b1, 3'd2, 32'd2, 32'd2);
    #1;
    chk("t6_reissue", 64'(mif.mul_start_o), 64'd1);
    step();
    idle();
    repeat (8) step();
    chk("t6_count", 64'(log_cid.size()), 64'd1);
    check_log("t6", 0, 3'd2, 32'd4);

    // Async reset with results buffered
    clear_log();
    wb_ready_i = 1'b0;
    set_req(5'd1, 1'b1, 3'd1, 32'd2, 32'd3);
    step();
    set_req(5'd2, 1'b1, 3'd2, 32'd4, 32'd3);
    step();
    idle();
    repeat (6) step();
    chk("t7_buffered", 64'(reg_we_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_we", 64'(reg_we_o), 64'd0);
    set_req(5'd9, 1'b1, 3'd3, 32'd4, 32'd4);
    #1;
    chk("t7_rst_start", 64'(mif.mul_start_o), 64'd1);
    idle();
    step();
    step();
    rst_n = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      set_req(AW'(i), 1'b1, CW'(i), XLEN'(i), 32'd4);
      #1;
      chk("t7_post_start", 64'(mif.mul_start_o), 64'd1);
      step();
    end
    idle();
    wb_ready_i = 1'b1;
    repeat (12) step();
    chk("t7_count", 64'(log_cid.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_log("t7", i, CW'(i + 3), XLEN'((i + 3) * 4));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
